// File: rtl/camera_emulator.sv
// Camera parallel-interface transmitter: pclk/vsync/href plus RGB565 bytes from a built-in pattern generator.
// Optional build macro CAMERA_EMU_MOTION_EN makes the square drift one pixel right per frame.
module camera_emulator #(
  parameter int H_ACTIVE    = 320,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 240,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 2,
  parameter int SQ_SIZE     = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [1:0]  pattern_sel_in,
  input  logic [15:0] color_in,
  input  logic [9:0]  sq_x_in,
  input  logic [8:0]  sq_y_in,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  pixel_out,
  output logic        frame_start_out,
  output logic [2:0]  state_out
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] H_LAST   = 11'(LINE_LEN - 1);
  localparam logic [10:0] H_BYTES  = 11'(2 * H_ACTIVE);
  localparam logic [7:0]  DIV_LAST = 8'(PCLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      state, state_n;
  logic [7:0]  div_cnt;
  logic [10:0] h_cnt, h_n;
  logic [8:0]  v_cnt, v_n, v_last;
  logic        div_last, fall_tick, load_frame;
  logic [1:0]  fr_pat;
  logic [15:0] fr_color;
  logic [9:0]  fr_sq_x;
  logic [8:0]  fr_sq_y;

  assign div_last  = (div_cnt == DIV_LAST);
  // Everything except pclk moves on the edge where pclk goes 1->0.
  assign fall_tick = div_last && pclk_out;
  assign state_out = state;

  always_comb begin
    case (state)
      S_VSYNC:  v_last = 9'(VSYNC_LINES - 1);
      S_VBACK:  v_last = 9'(V_BACK - 1);
      S_ACTIVE: v_last = 9'(V_ACTIVE - 1);
      S_VFRONT: v_last = 9'(V_FRONT - 1);
      default:  v_last = 9'd0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    h_n        = h_cnt;
    v_n        = v_cnt;
    load_frame = 1'b0;
    if (fall_tick) begin
      if (state == S_IDLE) begin
        if (enable_in) begin
          state_n    = S_VSYNC;
          h_n        = '0;
          v_n        = '0;
          load_frame = 1'b1;
        end
      end else if (h_cnt != H_LAST) begin
        h_n = h_cnt + 11'd1;
      end else begin
        h_n = '0;
        if (v_cnt != v_last) begin
          v_n = v_cnt + 9'd1;
        end else begin
          v_n = '0;
          case (state)
            S_VSYNC:  state_n = S_VBACK;
            S_VBACK:  state_n = S_ACTIVE;
            S_ACTIVE: state_n = S_VFRONT;
            S_VFRONT: begin
              // enable_in is only looked at here, so a frame is never cut short.
              if (enable_in) begin
                state_n    = S_VSYNC;
                load_frame = 1'b1;
              end else begin
                state_n = S_IDLE;
              end
            end
            default:  state_n = S_IDLE;
          endcase
        end
      end
    end
  end

  // Pixel for the position being entered, so the registered byte lines up with it.
  logic        href_n;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [9:0]  bar_q;
  logic [2:0]  bar_idx;
  logic [10:0] sq_x_end;
  logic [9:0]  sq_y_end;
  logic        in_sq;
  logic [15:0] px_color;
  logic [7:0]  byte_n;

  assign href_n   = (state_n == S_ACTIVE) && (h_n < H_BYTES);
  assign px_x     = h_n[10:1];
  assign px_y     = v_n;
  assign bar_q    = px_x / 10'(BAR_W);
  assign bar_idx  = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
  assign sq_x_end = {1'b0, fr_sq_x} + 11'(SQ_SIZE);
  assign sq_y_end = {1'b0, fr_sq_y} + 10'(SQ_SIZE);
  assign in_sq    = (px_x >= fr_sq_x) && ({1'b0, px_x} < sq_x_end) &&
                    (px_y >= fr_sq_y) && ({1'b0, px_y} < sq_y_end);

  always_comb begin
    px_color = 16'h0000;
    case (fr_pat)
      2'd0: px_color = fr_color;
      2'd1: begin
        case (bar_idx)
          3'd0:    px_color = 16'hFFFF;
          3'd1:    px_color = 16'hFFE0;
          3'd2:    px_color = 16'h07FF;
          3'd3:    px_color = 16'h07E0;
          3'd4:    px_color = 16'hF81F;
          3'd5:    px_color = 16'hF800;
          3'd6:    px_color = 16'h001F;
          default: px_color = 16'h0000;
        endcase
      end
      2'd2:    px_color = in_sq ? fr_color : 16'h0000;
      default: px_color = {px_x[4:0], px_x[5:0], px_x[4:0]};
    endcase
  end

  assign byte_n = href_n ? (h_n[0] ? px_color[7:0] : px_color[15:8]) : 8'h00;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_cnt         <= '0;
      pclk_out        <= 1'b0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      vsync_out       <= 1'b0;
      href_out        <= 1'b0;
      pixel_out       <= 8'h00;
      frame_start_out <= 1'b0;
      fr_pat          <= '0;
      fr_color        <= '0;
      fr_sq_x         <= '0;
      fr_sq_y         <= '0;
    end else begin
      frame_start_out <= 1'b0;
      h_cnt           <= h_n;
      v_cnt           <= v_n;
      if (div_last) begin
        div_cnt  <= '0;
        pclk_out <= ~pclk_out;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall_tick) begin
        vsync_out       <= (state_n == S_VSYNC);
        href_out        <= href_n;
        pixel_out       <= byte_n;
        frame_start_out <= (state_n == S_VSYNC) && (state != S_VSYNC);
      end
      if (load_frame) begin
        fr_pat   <= pattern_sel_in;
        fr_color <= color_in;
        fr_sq_y  <= sq_y_in;
`ifdef CAMERA_EMU_MOTION_EN
        if (state == S_IDLE)                   fr_sq_x <= sq_x_in;
        else if (fr_sq_x >= 10'(H_ACTIVE - 1)) fr_sq_x <= 10'd0;
        else                                   fr_sq_x <= fr_sq_x + 10'd1;
`else
        fr_sq_x <= sq_x_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_camera_emulator.sv
// Bench for camera_emulator: small-geometry instance for framing/patterns, wide instance for colour bars.
module tb_camera_emulator;

  localparam int HA = 4, HBL = 2, VA = 2, VS = 1, VBK = 1, VF = 1, PD = 2, SQ = 2;
  localparam int LINE    = 2 * HA + HBL;
  localparam int FRAME_P = LINE * (VS + VBK + VA + VF);
  localparam int HA_B    = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        a_en = 1'b0;
  logic [1:0]  a_pat = 2'd0;
  logic [15:0] a_col = 16'h0;
  logic [9:0]  a_sx = 10'd0;
  logic [8:0]  a_sy = 9'd0;
  logic        a_pclk, a_vsync, a_href, a_fs;
  logic [7:0]  a_pix;
  logic [2:0]  a_state;

  logic        b_en = 1'b0;
  logic [1:0]  b_pat = 2'd1;
  logic [15:0] b_col = 16'h0;
  logic [9:0]  b_sx = 10'd0;
  logic [8:0]  b_sy = 9'd0;
  logic        b_pclk, b_vsync, b_href, b_fs;
  logic [7:0]  b_pix;
  logic [2:0]  b_state;

  camera_emulator #(.H_ACTIVE(HA), .H_BLANK(HBL), .V_ACTIVE(VA), .VSYNC_LINES(VS),
                    .V_BACK(VBK), .V_FRONT(VF), .PCLK_DIV(PD), .SQ_SIZE(SQ)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .enable_in(a_en), .pattern_sel_in(a_pat),
    .color_in(a_col), .sq_x_in(a_sx), .sq_y_in(a_sy), .pclk_out(a_pclk),
    .vsync_out(a_vsync), .href_out(a_href), .pixel_out(a_pix),
    .frame_start_out(a_fs), .state_out(a_state));

  camera_emulator #(.H_ACTIVE(HA_B), .H_BLANK(HBL), .V_ACTIVE(VA), .VSYNC_LINES(VS),
                    .V_BACK(VBK), .V_FRONT(VF), .PCLK_DIV(PD), .SQ_SIZE(SQ)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .enable_in(b_en), .pattern_sel_in(b_pat),
    .color_in(b_col), .sq_x_in(b_sx), .sq_y_in(b_sy), .pclk_out(b_pclk),
    .vsync_out(b_vsync), .href_out(b_href), .pixel_out(b_pix),
    .frame_start_out(b_fs), .state_out(b_state));

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // independent reference of the pattern generator
  function automatic logic [15:0] exp_color(input logic [1:0] pat, input logic [15:0] col,
                                            input int sx, input int sy, input int x,
                                            input int y, input int hact);
    int bw, idx;
    logic [5:0] xb;
    exp_color = 16'h0000;
    case (pat)
      2'd0: exp_color = col;
      2'd1: begin
        bw = hact / 8;
        if (bw < 1) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        case (idx)
          0: exp_color = 16'hFFFF;
          1: exp_color = 16'hFFE0;
          2: exp_color = 16'h07FF;
          3: exp_color = 16'h07E0;
          4: exp_color = 16'hF81F;
          5: exp_color = 16'hF800;
          6: exp_color = 16'h001F;
          default: exp_color = 16'h0000;
        endcase
      end
      2'd2: exp_color = (x >= sx && x < sx + SQ && y >= sy && y < sy + SQ) ? col : 16'h0000;
      default: begin
        xb = 6'(x);
        exp_color = {xb[4:0], xb, xb[4:0]};
      end
    endcase
  endfunction

  // scoreboard: one {vsync, href, byte} entry per pclk period
  logic [9:0] exp_q[$];
  logic [7:0] b_exp_q[$];
  logic [9:0] mon_e;
  logic       mon_active = 1'b0;
  logic       a_pclk_q = 1'b0, a_vs_q = 1'b0, a_fs_q = 1'b0, b_pclk_q = 1'b0;
  int         cyc = 0, fs_total = 0, fs_last = 0, fs_gap = 0, b_bytes = 0;

  task automatic push_frame(input logic [1:0] pat, input logic [15:0] col, input int sx, input int sy);
    int line, h;
    logic vs, hr;
    logic [15:0] c;
    logic [7:0] b;
    for (int p = 0; p < FRAME_P; p++) begin
      line = p / LINE;
      h    = p % LINE;
      vs   = (line < VS);
      hr   = (line >= VS + VBK) && (line < VS + VBK + VA) && (h < 2 * HA);
      c    = exp_color(pat, col, sx, sy, h / 2, line - (VS + VBK), HA);
      b    = hr ? ((h % 2 == 1) ? c[7:0] : c[15:8]) : 8'h00;
      exp_q.push_back({vs, hr, b});
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (a_fs) begin
      fs_total++;
      fs_gap  = cyc - fs_last;
      fs_last = cyc;
      check_val("fs_on_vsync_rise", {30'd0, a_vs_q, a_vsync}, 32'd1);
      check_val("fs_one_cycle", {31'd0, a_fs_q}, 32'd0);
    end
    if (mon_active && a_pclk && !a_pclk_q && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_val("frame_sig", {22'd0, a_vsync, a_href, a_pix}, {22'd0, mon_e});
    end
    if (b_pclk && !b_pclk_q && b_href) begin
      b_bytes++;
      if (b_exp_q.size() > 0) check_val("bars_byte", {24'd0, b_pix}, {24'd0, b_exp_q.pop_front()});
    end
    a_pclk_q = a_pclk;
    a_vs_q   = a_vsync;
    a_fs_q   = a_fs;
    b_pclk_q = b_pclk;
  end

  // driver tasks
  task automatic wait_fs(input string tag, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (a_fs) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_href(input string tag, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (a_href) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic run_frames(input logic [1:0] pat, input logic [15:0] col, input int sx,
                            input int sy, input int nf);
    int fs0, sxf;
    bit ok;
    logic [9:0] acc;
    a_pat = pat;
    a_col = col;
    a_sx  = 10'(sx);
    a_sy  = 9'(sy);
    fs0   = fs_total;
    a_en  = 1'b1;
    wait_fs("first_frame_start", 4 * PD + 2, ok);
    if (ok) begin
      for (int f = 0; f < nf; f++) begin
`ifdef CAMERA_EMU_MOTION_EN
        sxf = (sx + f) % HA;
`else
        sxf = sx;
`endif
        push_frame(pat, col, sxf, sy);
      end
      mon_active = 1'b1;
      for (int k = 1; k < nf; k++) wait_fs("next_frame_start", FRAME_P * 2 * PD + 10, ok);
      // drop enable inside ACTIVE line 0 of the last frame
      wait_href("last_frame_href", FRAME_P * 2 * PD);
    end
    a_en = 1'b0;
    for (int i = 0; i < nf * FRAME_P * 2 * PD + 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_val("scoreboard_drained", exp_q.size(), 32'd0);
    mon_active = 1'b0;
    exp_q.delete();
    acc = '0;
    repeat (80) begin
      @(negedge clk);
      acc = acc | {a_vsync, a_href, a_pix};
    end
    check_val("idle_after_frames", {22'd0, acc}, 32'd0);
    check_val("frames_started", fs_total - fs0, nf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [15:0] bc;
  logic [10:0] acc11;
  int b0;
  bit bok;

  initial begin
    // reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("rst_pclk", {31'd0, a_pclk}, 32'd0);
    check_val("rst_vsync", {31'd0, a_vsync}, 32'd0);
    check_val("rst_href", {31'd0, a_href}, 32'd0);
    check_val("rst_pixel", {24'd0, a_pix}, 32'd0);
    check_val("rst_frame_start", {31'd0, a_fs}, 32'd0);
    check_val("rst_state", {29'd0, a_state}, 32'd0);
    check_val("rst_b_pclk", {31'd0, b_pclk}, 32'd0);
    check_val("rst_b_state", {29'd0, b_state}, 32'd0);

    // free-running pclk with enable low
    rst_n = 1'b1;
    acc11 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check_val("pclk_wave", {31'd0, a_pclk}, 32'((k / 2) % 2));
      acc11 = acc11 | {a_vsync, a_href, a_fs, a_pix};
    end
    check_val("idle_outputs_low", {21'd0, acc11}, 32'd0);

    // solid framing over two frames, then frame length in clocks
    run_frames(2'd0, 16'hF81F, 0, 0, 2);
    check_val("frame_len_clks", fs_gap, 32'(FRAME_P * 2 * PD));

    // colour bars on the 8-pixel-wide instance
    b0   = b_bytes;
    b_en = 1'b1;
    bok  = 1'b0;
    for (int i = 0; i < 4 * PD + 2; i++) begin
      @(negedge clk);
      if (b_fs) begin
        bok = 1'b1;
        break;
      end
    end
    check_val("bars_frame_start", {31'd0, bok}, 32'd1);
    for (int l = 0; l < VA; l++) begin
      for (int x = 0; x < HA_B; x++) begin
        bc = exp_color(2'd1, 16'h0, 0, 0, x, l, HA_B);
        b_exp_q.push_back(bc[15:8]);
        b_exp_q.push_back(bc[7:0]);
      end
    end
    b_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (b_exp_q.size() == 0) break;
    end
    check_val("bars_drained", b_exp_q.size(), 32'd0);
    repeat (100) @(negedge clk);
    check_val("bars_byte_count", b_bytes - b0, 32'(2 * HA_B * VA));
    b_exp_q.delete();

    // square clipped at the frame corner
    run_frames(2'd2, 16'h07E0, 3, 1, 1);
    // gradient
    run_frames(2'd3, 16'h0000, 0, 0, 1);
    // square over four consecutive frames (moves when motion is built in)
    run_frames(2'd2, 16'hFFFF, 2, 0, 4);

    // reset in the middle of href
    a_pat = 2'd0;
    a_col = 16'hF81F;
    a_en  = 1'b1;
    wait_href("href_before_reset", 8 * FRAME_P);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_href", {31'd0, a_href}, 32'd0);
    check_val("midrst_pixel", {24'd0, a_pix}, 32'd0);
    check_val("midrst_vsync", {31'd0, a_vsync}, 32'd0);
    check_val("midrst_pclk", {31'd0, a_pclk}, 32'd0);
    check_val("midrst_state", {29'd0, a_state}, 32'd0);
    a_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
